exc_commit_ctrl: RTL and testbench

//   Exception/ertn commit sequencer between the WB stage, the CSR file and IF.

---
 rtl/exc_commit_ctrl.sv | 147 ++++++++++++++
 tb/tb_exc_commit_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl: exception / ertn commit sequencer between WB, the CSR file and IF.
// It resolves the WB instruction's exception sources by fixed priority, pulses the
// CSR commit strobe for one cycle, holds the pipe flushed, hands the new fetch PC
// to IF over a valid/ready redirect, and then drains for DRAIN_CYC cycles.
// Optional feature macro: EXC_INT_EN (when defined, has_int raises an interrupt event
// with the highest priority; when undefined, has_int is ignored).
module exc_commit_ctrl #(
    parameter int DRAIN_CYC = 2,
    parameter int PC_W      = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            wb_valid,
    input  logic [PC_W-1:0] wb_pc,
    input  logic [4:0]      wb_exc,
    input  logic            wb_ertn,
    input  logic            has_int,
    input  logic [PC_W-1:0] ex_entry,
    input  logic [PC_W-1:0] ertn_entry,
    output logic            wb_ready,
    output logic            csr_wb_ex,
    output logic            csr_ertn_flush,
    output logic [5:0]      csr_ecode,
    output logic [8:0]      csr_esubcode,
    output logic [PC_W-1:0] csr_pc,
    output logic            pipe_flush,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    input  logic            redirect_ready
);

    localparam int CNT_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

    // wb_exc bit positions
    localparam int B_ADEF = 0;
    localparam int B_INE  = 1;
    localparam int B_SYS  = 2;
    localparam int B_BRK  = 3;
    localparam int B_ALE  = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMMIT,
        S_REDIRECT,
        S_DRAIN
    } state_t;

    // Event captured in IDLE and replayed to the CSR file in COMMIT
    typedef struct packed {
        logic            is_ertn;
        logic [5:0]      ecode;
        logic [PC_W-1:0] pc;
    } evt_t;

    state_t          state_q, state_d;
    evt_t            evt_q, evt_d;
    logic [PC_W-1:0] target_q;
    logic [CNT_W-1:0] drain_cnt_q;
    logic            int_req;
    logic            evt_hit;

`ifdef EXC_INT_EN
    assign int_req = has_int;
`else
    logic int_unused;
    assign int_unused = has_int;
    assign int_req    = 1'b0;
`endif

    assign evt_hit = wb_valid & (int_req | (|wb_exc) | wb_ertn);

    // Priority resolve: INT > ADEF > INE > SYS > BRK > ALE > ERTN
    always_comb begin
        evt_d         = '0;
        evt_d.pc      = wb_pc;
        if (int_req)             evt_d.ecode = 6'h00;
        else if (wb_exc[B_ADEF]) evt_d.ecode = 6'h08;
        else if (wb_exc[B_INE])  evt_d.ecode = 6'h0D;
        else if (wb_exc[B_SYS])  evt_d.ecode = 6'h0B;
        else if (wb_exc[B_BRK])  evt_d.ecode = 6'h0C;
        else if (wb_exc[B_ALE])  evt_d.ecode = 6'h09;
        else                     evt_d.is_ertn = 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_d        = state_q;
        wb_ready       = 1'b0;
        csr_wb_ex      = 1'b0;
        csr_ertn_flush = 1'b0;
        csr_ecode      = '0;
        csr_esubcode   = '0;
        csr_pc         = '0;
        pipe_flush     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state_q)
            S_IDLE: begin
                wb_ready   = 1'b1;
                pipe_flush = 1'b0;
                if (evt_hit) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                csr_wb_ex      = ~evt_q.is_ertn;
                csr_ertn_flush = evt_q.is_ertn;
                if (!evt_q.is_ertn) begin
                    csr_ecode = evt_q.ecode;
                    csr_pc    = evt_q.pc;
                end
                state_d = S_REDIRECT;
            end
            S_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
                if (redirect_ready) state_d = (DRAIN_CYC == 0) ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt_q <= CNT_W'(1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Event latch, redirect target and drain counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            evt_q       <= '0;
            target_q    <= '0;
            drain_cnt_q <= '0;
        end else begin
            if (state_q == S_IDLE && evt_hit) evt_q <= evt_d;
            if (state_q == S_COMMIT)
                target_q <= evt_q.is_ertn ? ertn_entry : ex_entry;
            if (state_q == S_REDIRECT)
                drain_cnt_q <= CNT_W'(DRAIN_CYC);
            else if (state_q == S_DRAIN)
                drain_cnt_q <= drain_cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Bench for exc_commit_ctrl: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a transaction-level model.
module tb_exc_commit_ctrl;

    localparam int DRAIN = 2;
    localparam int PC_W  = 32;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            wb_valid = 1'b0;
    logic [PC_W-1:0] wb_pc = '0;
    logic [4:0]      wb_exc = '0;
    logic            wb_ertn = 1'b0;
    logic            has_int = 1'b0;
    logic [PC_W-1:0] ex_entry = '0;
    logic [PC_W-1:0] ertn_entry = '0;
    logic            redirect_ready = 1'b0;
    logic            wb_ready, csr_wb_ex, csr_ertn_flush, pipe_flush, redirect_valid;
    logic [5:0]      csr_ecode;
    logic [8:0]      csr_esubcode;
    logic [PC_W-1:0] csr_pc, redirect_pc;

    exc_commit_ctrl #(.DRAIN_CYC(DRAIN), .PC_W(PC_W)) dut (
        .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_exc(wb_exc), .wb_ertn(wb_ertn), .has_int(has_int),
        .ex_entry(ex_entry), .ertn_entry(ertn_entry), .wb_ready(wb_ready),
        .csr_wb_ex(csr_wb_ex), .csr_ertn_flush(csr_ertn_flush),
        .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode), .csr_pc(csr_pc),
        .pipe_flush(pipe_flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Ecode per wb_exc bit, bit order is also the priority order (bit 0 highest).
    function automatic logic [5:0] code_of(input int i);
        case (i)
            0: return 6'h08;  // adef
            1: return 6'h0D;  // ine
            2: return 6'h0B;  // sys
            3: return 6'h0C;  // brk
            default: return 6'h09;  // ale
        endcase
    endfunction

    bit         e_hit, e_ertn;
    logic [5:0] e_code;
    always_comb begin
        bit intr;
        intr   = 1'b0;
        e_hit  = 1'b0;
        e_ertn = 1'b0;
        e_code = '0;
`ifdef EXC_INT_EN
        intr = has_int;
`endif
        if (wb_valid) begin
            if (intr) begin
                e_hit = 1'b1;
            end else if (wb_exc != 0) begin
                e_hit = 1'b1;
                for (int i = 4; i >= 0; i--) if (wb_exc[i]) e_code = code_of(i);
            end else if (wb_ertn) begin
                e_hit  = 1'b1;
                e_ertn = 1'b1;
            end
        end
    end

    // A transaction: one pulse cycle, a redirect that lasts until accepted,
    // then DRAIN flush cycles. Nothing new is accepted while any part is pending.
    bit              m_commit = 0, m_redir = 0, m_ertn = 0;
    int              m_drain = 0;
    logic [5:0]      m_code = '0;
    logic [PC_W-1:0] m_pc = '0, m_tgt = '0;
    bit              m_busy;
    assign m_busy = m_commit || m_redir || (m_drain > 0);

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_commit <= 0;
            m_redir  <= 0;
            m_drain  <= 0;
        end else if (m_commit) begin
            m_commit <= 0;
            m_redir  <= 1;
            m_tgt    <= m_ertn ? ertn_entry : ex_entry;
        end else if (m_redir) begin
            if (redirect_ready) begin
                m_redir <= 0;
                m_drain <= DRAIN;
            end
        end else if (m_drain > 0) begin
            m_drain <= m_drain - 1;
        end else if (e_hit) begin
            m_commit <= 1;
            m_ertn   <= e_ertn;
            m_code   <= e_code;
            m_pc     <= wb_pc;
        end
    end

    // Compare DUT against model every cycle, away from the active edge
    always @(negedge clk) begin
        chk("wb_ready", wb_ready, !m_busy);
        chk("pipe_flush", pipe_flush, m_busy);
        chk("csr_wb_ex", csr_wb_ex, m_commit && !m_ertn);
        chk("csr_ertn_flush", csr_ertn_flush, m_commit && m_ertn);
        chk("redirect_valid", redirect_valid, m_redir);
        chk("csr_esubcode", csr_esubcode, 0);
        if (m_commit && !m_ertn) begin
            chk("csr_ecode", csr_ecode, m_code);
            chk("csr_pc", csr_pc, m_pc);
        end
        if (m_redir) chk("redirect_pc", redirect_pc, m_tgt);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        wb_valid = 0; wb_exc = 0; wb_ertn = 0; has_int = 0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!wb_ready && k < 40) begin
            step();
            k++;
        end
        chk("wait_idle_timeout", wb_ready, 1);
    endtask

    logic [PC_W-1:0] held_pc;

    initial begin
        redirect_ready = 1;
        #12;
        // reset values
        chk("rst_wb_ready", wb_ready, 1);
        chk("rst_pipe_flush", pipe_flush, 0);
        chk("rst_csr_wb_ex", csr_wb_ex, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        step();
        resetn = 1;
        step();

        // SYS only
        wb_valid = 1; wb_exc = 5'b00100; wb_pc = 32'h1c000100;
        ex_entry = 32'h1c008000; ertn_entry = 32'h1c00dead;
        step(); clr_in();
        chk("sys_pulse", csr_wb_ex, 1);
        chk("sys_ecode", csr_ecode, 6'h0B);
        chk("sys_pc", csr_pc, 32'h1c000100);
        chk("sys_no_ertn", csr_ertn_flush, 0);
        step();
        chk("sys_pulse_once", csr_wb_ex, 0);
        chk("sys_rdir_v", redirect_valid, 1);
        chk("sys_rdir_pc", redirect_pc, 32'h1c008000);
        step();
        chk("sys_drain1", wb_ready, 0);
        chk("sys_drain1_flush", pipe_flush, 1);
        step();
        chk("sys_drain2", wb_ready, 0);
        step();
        chk("sys_idle", wb_ready, 1);
        chk("sys_idle_flush", pipe_flush, 0);

        // ertn
        wb_valid = 1; wb_ertn = 1; wb_pc = 32'h1c000300; ertn_entry = 32'h1c000204;
        step(); clr_in();
        chk("ertn_flush", csr_ertn_flush, 1);
        chk("ertn_no_ex", csr_wb_ex, 0);
        step();
        chk("ertn_rdir_pc", redirect_pc, 32'h1c000204);
        wait_idle();

        // adef + ale + ertn: exception wins
        wb_valid = 1; wb_exc = 5'b10001; wb_ertn = 1; wb_pc = 32'h1c000400;
        step(); clr_in();
        chk("adef_ecode", csr_ecode, 6'h08);
        chk("adef_pulse", csr_wb_ex, 1);
        chk("adef_no_ertn", csr_ertn_flush, 0);
        wait_idle();

        // interrupt in the same mix
        wb_valid = 1; wb_exc = 5'b10001; wb_ertn = 1; has_int = 1; wb_pc = 32'h1c000500;
        step(); clr_in();
`ifdef EXC_INT_EN
        chk("int_ecode", csr_ecode, 6'h00);
        chk("int_pc", csr_pc, 32'h1c000500);
`else
        chk("noint_ecode", csr_ecode, 6'h08);
`endif
        wait_idle();

        // redirect_ready low for 4 cycles
        redirect_ready = 0; ex_entry = 32'h1c00a000;
        wb_valid = 1; wb_exc = 5'b01000; wb_pc = 32'h1c000600;
        step(); clr_in();
        chk("brk_ecode", csr_ecode, 6'h0C);
        for (int i = 0; i < 4; i++) begin
            step();
            ex_entry = $urandom;
            chk("stall_valid", redirect_valid, 1);
            chk("stall_pc", redirect_pc, 32'h1c00a000);
            chk("stall_flush", pipe_flush, 1);
        end
        redirect_ready = 1;
        step();
        chk("resume_drain", redirect_valid, 0);
        chk("resume_flush", pipe_flush, 1);
        wait_idle();

        // reset during REDIRECT
        redirect_ready = 0;
        wb_valid = 1; wb_exc = 5'b00010; wb_pc = 32'h1c000700;
        step(); clr_in();
        step();
        chk("pre_rst_rdir", redirect_valid, 1);
        resetn = 0;
        #1;
        chk("rst_mid_rdir", redirect_valid, 0);
        chk("rst_mid_flush", pipe_flush, 0);
        chk("rst_mid_ready", wb_ready, 1);
        step();
        resetn = 1; redirect_ready = 1;
        step();
        wb_valid = 1; wb_exc = 5'b00010; wb_pc = 32'h1c000800;
        step(); clr_in();
        chk("post_rst_pulse", csr_wb_ex, 1);
        chk("post_rst_ecode", csr_ecode, 6'h0D);
        wait_idle();

        // has_int alone
        wb_valid = 1; has_int = 1; wb_pc = 32'h1c000900;
        step(); clr_in();
`ifdef EXC_INT_EN
        chk("int_only_pulse", csr_wb_ex, 1);
        chk("int_only_ecode", csr_ecode, 6'h00);
`else
        chk("int_ignored_ready", wb_ready, 1);
        chk("int_ignored_pulse", csr_wb_ex, 0);
`endif
        wait_idle();

        // randomized run
        for (int c = 0; c < 3000; c++) begin
            wb_valid       = 1'($urandom_range(0, 1));
            wb_exc         = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
            wb_ertn        = ($urandom_range(0, 3) == 0);
            has_int        = ($urandom_range(0, 4) == 0);
            wb_pc          = $urandom;
            ex_entry       = $urandom;
            ertn_entry     = $urandom;
            redirect_ready = ($urandom_range(0, 9) < 7);
            resetn         = ($urandom_range(0, 199) != 0);
            step();
        end
        resetn = 1;
        clr_in();
        step();
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
